// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode CPU.
//  - opcode_t      : instruction opcodes (instr[15:12])
//  - OPC_MSB/LSB   : opcode field position inside a 16-bit instruction
//  - INSTR_BYTES   : PC increment per instruction
//  - fetch_state_t : fetch stage FSM states
//  - FETCH_DEPTH   : fetch credit depth (in-flight requests + buffered words)
// Configuration macro: IFETCH_PREFETCH_EN
//  defined   -> FETCH_DEPTH = 2 (two requests in flight, streaming possible)
//  undefined -> FETCH_DEPTH = 1 (single request in flight)
package cpu_pkg;

    typedef enum logic [3:0] {
        OPC_ADD = 4'h0,
        OPC_SUB = 4'h1,
        OPC_XOR = 4'h2,
        OPC_NOR = 4'h3,
        OPC_AND = 4'h4,
        OPC_ROT = 4'h5,
        OPC_ROI = 4'h6,
        OPC_JLR = 4'h7,
        OPC_JLI = 4'h8,
        OPC_BRX = 4'h9,
        OPC_ADI = 4'hC,
        OPC_STB = 4'hD,
        OPC_LDB = 4'hE,
        OPC_LDI = 4'hF
    } opcode_t;

    localparam int OPC_MSB     = 15;
    localparam int OPC_LSB     = 12;
    localparam int OPC_W       = OPC_MSB - OPC_LSB + 1;
    localparam int INSTR_BYTES = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

`ifdef IFETCH_PREFETCH_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

endpackage

// File: rtl/ifetch_fifo.sv
// Small shift-register FIFO used by the fetch stage, both for the returned
// instruction buffer and for the queue of in-flight request PCs.
// Entry 0 is always the head, so the read is a plain register output.
// Ports:
//  clk, rst  clock, asynchronous active-high reset
//  clear     synchronous flush (wins over push/pop)
//  push/din  write an entry (ignored when full without a pop)
//  pop       remove the head (ignored when empty)
//  count     number of valid entries (0..DEPTH)
//  head      oldest entry (meaningful when count != 0)
module ifetch_fifo #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic pop_eff;
    logic push_eff;

    assign pop_eff  = pop && (count != '0);
    // Push while full is accepted only together with a pop.
    assign push_eff = push && (pop_eff || (count != FULL));
    assign head     = mem[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop_eff) begin
                    // Shift toward the head; a simultaneous push lands in the
                    // slot just below the old tail.
                    if (push_eff && (CNT_W'(i + 1) == count)) begin
                        mem[i] <= din;
                    end else begin
                        mem[i] <= mem[(i + 1) % DEPTH];
                    end
                end else if (push_eff && (CNT_W'(i) == count)) begin
                    mem[i] <= din;
                end
            end
            if (push_eff && !pop_eff) begin
                count <= count + ONE;
            end else if (pop_eff && !push_eff) begin
                count <= count - ONE;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of the 4-bit-opcode CPU.
// Owns the PC, issues in-order word reads to instruction memory, buffers the
// returned words and hands them to decode. Taken branches/jumps redirect the
// PC and every in-flight or buffered wrong-path instruction is discarded.
// Configuration macro: IFETCH_PREFETCH_EN (see cpu_pkg, sets FETCH_DEPTH).
// Ports:
//  clk, rst                       clock, asynchronous active-high reset
//  imem_req_valid/ready/addr      read request (addr = fetch PC)
//  imem_rsp_valid/data            in-order read response, no backpressure
//  redirect_valid/pc              taken branch/jump target (bit0 ignored)
//  id_valid/ready                 decode handshake
//  id_instr/id_pc/id_opcode       instruction, its address, instr[15:12]
// Handshakes: a transfer happens on a cycle where valid && ready are both 1.
// A request may be withdrawn or change address before it is accepted.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = 'h0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [OPC_W-1:0]   id_opcode
);

    localparam int DEPTH = FETCH_DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    fetch_state_t state, state_n;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] outstanding, outstanding_n;
    logic [CNT_W-1:0] stale, stale_n;
    logic [CNT_W-1:0] fifo_count;
    logic [PC_W-1:0]  rsp_pc;
    logic [INSTR_W+PC_W-1:0] fifo_head;
    logic req_fire;
    logic rsp_keep;
    logic id_fire;
    logic redirect_pc_lsb_unused;

    assign redirect_pc_lsb_unused = redirect_pc[0];

    // Credits cover both in-flight requests and buffered words, so a
    // response can always be written without overflowing the buffer.
    assign imem_req_valid = (state != BOOT) && !redirect_valid &&
                            (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses belonging to a killed path, or arriving with a redirect, are dropped.
    assign rsp_keep = imem_rsp_valid && (stale == '0) && !redirect_valid;

    assign id_valid = (fifo_count != '0);
    assign id_fire  = id_valid && id_ready && !redirect_valid;

    // Queue of request PCs in issue order; its occupancy is the in-flight count.
    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W)
    ) u_pc_q (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .push  (req_fire),
        .din   (pc),
        .pop   (imem_rsp_valid),
        .count (outstanding),
        .head  (rsp_pc)
    );

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + PC_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (rsp_keep),
        .din   ({imem_rsp_data, rsp_pc}),
        .pop   (id_fire),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_comb begin
        outstanding_n = outstanding;
        if (req_fire) begin
            outstanding_n = outstanding_n + ONE;
        end
        if (imem_rsp_valid) begin
            outstanding_n = outstanding_n - ONE;
        end
    end

    // On a redirect every request still in flight is wrong-path. Requests
    // already marked stale are part of that in-flight count, so the new stale
    // count is simply the post-handshake in-flight count.
    always_comb begin
        stale_n = stale;
        if (redirect_valid) begin
            stale_n = outstanding_n;
        end else if (imem_rsp_valid && (stale != '0)) begin
            stale_n = stale - ONE;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            BOOT:    state_n = RUN;
            RUN:     if (redirect_valid && (outstanding_n != '0)) state_n = FLUSH;
            FLUSH:   if (stale_n == '0) state_n = RUN;
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            stale <= '0;
        end else begin
            state <= state_n;
            stale <= stale_n;
            if (redirect_valid) begin
                pc <= {redirect_pc[PC_W-1:1], 1'b0};
            end else if (req_fire) begin
                pc <= pc + PC_W'(INSTR_BYTES);
            end
        end
    end

    // Outputs are forced to zero whenever nothing is presented.
    assign id_instr  = id_valid ? fifo_head[PC_W +: INSTR_W] : '0;
    assign id_pc     = id_valid ? fifo_head[PC_W-1:0] : '0;
    assign id_opcode = id_instr[INSTR_W-1 -: OPC_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table after reset, then hand-written
// sequences for stall, redirect, PC wrap and mid-operation reset.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int DEPTH = FETCH_DEPTH;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [3:0]  id_opcode;

    instr_fetch #(
        .PC_W     (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // bench state
    int vectors = 0;
    int fails   = 0;
    int cyc;
    int lat;
    int req_fires;
    int delivered;
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    logic [15:0] req_log[$];
    logic [15:0] exp_q[$];

    function automatic logic [15:0] word(input logic [15:0] a);
        logic [15:0] r;
        r = a * 16'h9E37;
        return r ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        fails++;
        $display("FAIL %s: cycle budget expired, got no event expected event", name);
    endtask

    task automatic fill_exp(input logic [15:0] start);
        logic [15:0] p;
        p = start;
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            exp_q.push_back(p);
            p = p + 16'd2;
        end
    endtask

    // driver tasks: observe handshakes mid-cycle, then move to the next cycle
    task automatic sample_edge();
        logic [15:0] e;
        logic [15:0] w;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            req_log.push_back(imem_req_addr);
            req_fires++;
        end
        if (id_valid && id_ready && !redirect_valid) begin
            delivered++;
            if (exp_q.size() == 0) begin
                timeout_fail("id_unexpected");
            end else begin
                e = exp_q.pop_front();
                w = word(e);
                chk("id_pc", id_pc, e);
                chk("id_instr", id_instr, w);
                chk("id_opcode", id_opcode, w[15:12]);
            end
        end
        if (redirect_valid) begin
            fill_exp({redirect_pc[15:1], 1'b0});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(pend_addr.pop_front());
            pend_due.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic step();
        sample_edge();
        advance();
    endtask

    task automatic run_until_delivered(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (delivered < target && n < budget) begin
            step();
            n++;
        end
        if (delivered < target) timeout_fail(name);
    endtask

    task automatic do_reset(input int l, input logic rdy);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = rdy;
        lat            = l;
        pend_addr.delete();
        pend_due.delete();
        req_log.delete();
        req_fires = 0;
        delivered = 0;
        fill_exp(16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_opcode", id_opcode, 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    // per-cycle table after reset release (latency 1, id_ready 1)
    typedef struct {
        logic        id_ready;
        logic        exp_req_valid;
        logic [15:0] exp_req_addr;
        logic        exp_id_valid;
        logic [15:0] exp_id_pc;
    } vec_t;

    vec_t tbl[8];
    int   idx;
    int   n;

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b1;
        cyc            = 0;
        lat            = 1;

`ifdef IFETCH_PREFETCH_EN
        tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002};
        tbl[5] = '{1'b1, 1'b1, 16'h0006, 1'b0, 16'h0000};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004};
        tbl[7] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006};
`else
        tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};
        tbl[7] = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
`endif

        // 1: reset release, first fetches
        do_reset(1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            id_ready = tbl[i].id_ready;
            #1;
            chk($sformatf("t1_req_valid_c%0d", i), imem_req_valid, tbl[i].exp_req_valid);
            if (tbl[i].exp_req_valid)
                chk($sformatf("t1_req_addr_c%0d", i), imem_req_addr, tbl[i].exp_req_addr);
            chk($sformatf("t1_id_valid_c%0d", i), id_valid, tbl[i].exp_id_valid);
            if (tbl[i].exp_id_valid)
                chk($sformatf("t1_id_pc_c%0d", i), id_pc, tbl[i].exp_id_pc);
            step();
        end

        // 2: decode stalled, buffer fills, nothing lost
        do_reset(1, 1'b0);
        repeat (6) step();
        chk("t2_req_fires", req_fires, DEPTH);
        chk("t2_req_valid_full", imem_req_valid, 0);
        chk("t2_id_valid", id_valid, 1);
        chk("t2_head_pc", id_pc, 16'h0000);
        chk("t2_head_instr", id_instr, word(16'h0000));
        id_ready = 1'b1;
        run_until_delivered(6, 60, "t2_deliver");

        // 3: redirect with requests in flight
        do_reset(1, 1'b1);
        n = 0;
        while (req_fires < 4 && n < 40) begin
            step();
            n++;
        end
        if (req_fires < 4) timeout_fail("t3_first_reqs");
        imem_req_ready = 1'b0;
        repeat (8) step();
        chk("t3_drained", delivered, 4);
        lat = 4;
        imem_req_ready = 1'b1;
        n = 0;
        while (pend_addr.size() < DEPTH && n < 10) begin
            step();
            n++;
        end
        if (pend_addr.size() < DEPTH) timeout_fail("t3_inflight");
        else chk("t3_inflight_addr0", pend_addr[0], 16'h0008);
        if (DEPTH > 1 && pend_addr.size() > 1) chk("t3_inflight_addr1", pend_addr[1], 16'h000A);
        idx = req_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        #1;
        chk("t3_req_valid_redirect", imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        run_until_delivered(7, 80, "t3_deliver");
        if (req_log.size() > idx) chk("t3_next_req_addr", req_log[idx], 16'h0040);
        else timeout_fail("t3_next_req");

        // 4: redirect together with id handshake and a response
        do_reset(1, 1'b1);
        n = 0;
        while (!(id_valid && (DEPTH == 1 || imem_rsp_valid)) && n < 20) begin
            step();
            n++;
        end
        if (!id_valid) timeout_fail("t4_setup");
        idx = req_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t4_id_valid_after", id_valid, 0);
        step();
        chk("t4_id_valid_after2", id_valid, 0);
        run_until_delivered(delivered + 3, 40, "t4_deliver");
        if (req_log.size() > idx) chk("t4_next_req_addr", req_log[idx], 16'h0100);
        else timeout_fail("t4_next_req");

        // 5: PC wrap at the top of the address space
        do_reset(1, 1'b1);
        step();
        idx = req_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        run_until_delivered(3, 40, "t5_deliver");
        if (req_log.size() > idx + 1) begin
            chk("t5_req0", req_log[idx], 16'hFFFE);
            chk("t5_req1", req_log[idx+1], 16'h0000);
        end else begin
            timeout_fail("t5_reqs");
        end

        // 6: asynchronous reset mid-operation
        do_reset(3, 1'b0);
        n = 0;
        while (!(id_valid && (pend_addr.size() + int'(imem_rsp_valid)) == DEPTH - 1) && n < 20) begin
            step();
            n++;
        end
        if (!id_valid) timeout_fail("t6_setup");
        #1;
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        #1;
        chk("t6_id_valid_rst", id_valid, 0);
        chk("t6_req_valid_rst", imem_req_valid, 0);
        chk("t6_id_pc_rst", id_pc, 0);
        do_reset(1, 1'b1);
        run_until_delivered(2, 30, "t6_deliver");
        if (req_log.size() > 0) chk("t6_restart_addr", req_log[0], 16'h0000);
        else timeout_fail("t6_restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
